// File: rtl/alu_op_sequencer.sv
// Stimulus/capture engine for a registered ALU: sweeps every opcode over three latched
// operands, streams each captured result with its opcode, and sums them into a signature.
module alu_op_sequencer #(
  parameter int DATA_W  = 4,
  parameter int SEL_W   = 3,
  parameter int RET_W   = 5,
  parameter int NUM_OPS = 8,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a_in,
  input  logic [DATA_W-1:0] op_b_in,
  input  logic [DATA_W-1:0] op_c_in,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_c,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [RET_W-1:0]  alu_ret,
  output logic              busy,
  output logic              res_valid,
  output logic [SEL_W-1:0]  res_idx,
  output logic [RET_W-1:0]  res_data,
  output logic [RET_W+2:0]  signature,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [3:0]       LAT     = 4'(ALU_LAT);
  localparam logic [SEL_W-1:0] LAST_OP = SEL_W'(NUM_OPS - 1);

  state_t     state;
  logic [3:0] wait_cnt;

  assign dbg_state = state;

  // Result stream handshake: res_valid is a one-cycle strobe with no back-pressure; a
  // consumer must take res_idx/res_data in the cycle res_valid is high. done pulses for
  // exactly one cycle, coincident with the last result strobe, and busy drops one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_c     <= '0;
      alu_sel   <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
      signature <= '0;
      done      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            alu_a     <= op_a_in;
            alu_b     <= op_b_in;
            alu_c     <= op_c_in;
            alu_sel   <= '0;
            signature <= '0;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= LAT;
          state    <= (ALU_LAT == 0) ? S_CAPTURE : S_WAIT;
        end
        S_WAIT: begin
          // Count holds the remaining wait cycles including the current one.
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          res_data  <= alu_ret;
          res_idx   <= alu_sel;
          res_valid <= 1'b1;
          signature <= signature + (RET_W+3)'(alu_ret);
          if (alu_sel == LAST_OP) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            alu_sel <= alu_sel + SEL_W'(1);
            state   <= S_ISSUE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
